apb_reg_slave: RTL and testbench
================================

Name: apb_reg_slave

Overview:
APB slave register file that sits directly downstream of apb_add_master. It consumes the master's psel/penable/paddr/pwrite/pwdata and returns prdata/pready, and adds a configurable number of wait states. It holds NUM_REGS 32-bit registers. Offset 0 is a read-only ID register. Bad accesses are reported via pslverr. It replaces the behavioural slave in the master's bench as the synthesizable target.

Parameters:
NUM_REGS, 8, number of 32-bit registers including ID register (min 2)
BASE_ADDR, 32'h0000_0000, byte address of register 0
WAIT_CYCLES, 0, extra wait states inserted before pready_o (0..15)
ID_VALUE, 32'hA5B0_0001, constant returned by register 0

Ports:
pclk  in  1  APB clock; all state updates on rising edge
preset_n  in  1  asynchronous active-low reset
psel_i  in  1  slave select from master
penable_i  in  1  access-phase strobe from master
paddr_i  in  32  byte address
pwrite_i  in  1  1 = write, 0 = read
pwdata_i  in  32  write data
prdata_o  out  32  read data, valid while pready_o = 1
pready_o  out  1  transfer complete, one-cycle pulse
pslverr_o  out  1  error response, valid only while pready_o = 1

Behaviour:
- Reset: one clock pclk; asynchronous active-low reset preset_n.
  - When preset_n = 0, pready_o=0, pslverr_o=0, prdata_o=0, FSM=IDLE, wait counter=0, registers 1..NUM_REGS-1=0.
  - Assertion mid-transfer aborts immediately. No write commits.
- Address decode (combinational): off = paddr_i - BASE_ADDR.
  - valid = (paddr_i >= BASE_ADDR) && (paddr_i[1:0]==0) && (off < 4*NUM_REGS); idx = off>>2.
  - err = !valid || (pwrite_i && idx==0).
- FSM states:
  - IDLE: on an edge sampling psel_i&&penable_i, go to WAIT and load cnt=WAIT_CYCLES.
  - WAIT: if cnt==0, go to READY, assert pready_o and pslverr_o=err, and load prdata_o. Otherwise decrement cnt.
  - READY: pready_o=1 for exactly this cycle. At the edge ending it:
    - if psel_i&&penable_i&&pwrite_i&&!err, write regs[idx]=pwdata_i;
    - clear pready_o, pslverr_o and prdata_o;
    - return to IDLE.
- Latency: with first access cycle counted as 1, pready_o is high in access cycle WAIT_CYCLES+2. With WAIT_CYCLES=0, a psel rising at edge E0 gives penable at E1, pready high from E2 to E3, and write commit at E3.
- Read data:
  - idx 0 returns ID_VALUE.
  - Other valid idx returns regs[idx], sampled when entering READY.
  - Error reads return 32'h0.
- Errors: pslverr_o=1 with pready_o, and register contents are unchanged. Covered cases:
  - misaligned address;
  - address below base or beyond range;
  - write to ID register.
- Protocol violation: if psel_i or penable_i drops during WAIT, return to IDLE next edge. No pready_o, no write.
- Back-to-back: after READY the FSM is IDLE. The next transfer's setup cycle has penable_i=0, so no spurious restart occurs. A penable_i held high into a new psel_i is treated as a new access.
- Address, pwrite_i and pwdata_i are taken from the READY cycle. The master must hold them stable across the access phase, per APB.

Test Plan:
1. Reset, then WAIT_CYCLES=0 read of 32'h0 -> prdata_o=32'hA5B0_0001, pready_o high exactly 1 cycle (2nd access cycle), pslverr_o=0.
2. Write 32'hDEAD_BEEF to 32'h4, then read 32'h4 -> read returns 32'hDEAD_BEEF, both transfers pslverr_o=0; read 32'h8 returns 32'h0.
3. WAIT_CYCLES=3: write 32'h1234_5678 to 32'h1C -> pready_o rises in access cycle 5; a read of 32'h1C afterwards returns 32'h1234_5678.
4. Errors:
   - write to 32'h0 -> pslverr_o=1, ID unchanged;
   - read 32'h20 (NUM_REGS=8) -> pslverr_o=1, prdata_o=0;
   - write 32'h6 -> pslverr_o=1, regs unchanged.
5. WAIT_CYCLES=3, start write to 32'h8, drop psel_i in wait cycle 2 -> no pready_o; reg 2 stays 0. Also assert preset_n=0 mid-wait of a write to 32'hC -> all outputs 0, reg 3 stays 0.
6. Back-to-back: write 32'h10, then immediately read 32'h10 with apb_add_master driving (add_i=2'b11, then 2'b01) -> read returns written value; exactly one pready_o pulse per transfer.

Source files
------------

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between apb_add_master and apb_reg_slave.
// Signal suffixes are named from the slave's point of view.
interface apb_reg_slave_if;
   logic        psel_i;
   logic        penable_i;
   logic [31:0] paddr_i;
   logic        pwrite_i;
   logic [31:0] pwdata_i;
   logic [31:0] prdata_o;
   logic        pready_o;
   logic        pslverr_o;

   modport master (
      output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      input  prdata_o, pready_o, pslverr_o
   );

   modport slave (
      input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      output prdata_o, pready_o, pslverr_o
   );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register-file slave: read-only ID at offset 0, NUM_REGS-1 RW registers,
// programmable wait states and pslverr on bad accesses.
module apb_reg_slave #(
   parameter int unsigned NUM_REGS    = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input logic               pclk,
   input logic               preset_n,
   apb_reg_slave_if.slave    apb
);

   localparam int unsigned IDX_W     = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
   localparam logic [32:0] SPAN      = 33'(4 * NUM_REGS);
   // The IDLE->WAIT edge already counts as the first wait state.
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_READY
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_pready;
   logic        r_pslverr;
   logic [31:0] r_prdata;
   logic [31:0] r_regs [NUM_REGS];

   logic [31:0]      w_off;
   logic             w_valid;
   logic [IDX_W-1:0] w_idx;
   logic             w_err;
   logic [31:0]      w_rdata;
   logic             w_access;

   // Address decode
   assign w_off    = apb.paddr_i - BASE_ADDR;
   assign w_valid  = (apb.paddr_i >= BASE_ADDR) && (apb.paddr_i[1:0] == 2'b00) &&
                     ({1'b0, w_off} < SPAN);
   assign w_idx    = w_off[IDX_W+1:2];
   assign w_err    = !w_valid || (apb.pwrite_i && (w_idx == '0));
   assign w_rdata  = w_err ? 32'h0 : ((w_idx == '0) ? ID_VALUE : r_regs[w_idx]);
   assign w_access = apb.psel_i && apb.penable_i;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= 32'h0;
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_regs[i] <= 32'h0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  if (WAIT_CYCLES == 0) begin
                     r_state   <= S_READY;
                     r_pready  <= 1'b1;
                     r_pslverr <= w_err;
                     r_prdata  <= w_rdata;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= WAIT_LOAD;
                  end
               end
            end
            S_WAIT: begin
               // Master abandoned the access: drop it without a response.
               if (!w_access) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end else if (r_cnt == 4'd0) begin
                  r_state   <= S_READY;
                  r_pready  <= 1'b1;
                  r_pslverr <= w_err;
                  r_prdata  <= w_rdata;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_READY: begin
               if (w_access && apb.pwrite_i && !w_err) begin
                  r_regs[w_idx] <= apb.pwdata_i;
               end
               r_state   <= S_IDLE;
               r_pready  <= 1'b0;
               r_pslverr <= 1'b0;
               r_prdata  <= 32'h0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign apb.prdata_o  = r_prdata;
   assign apb.pready_o  = r_pready;
   assign apb.pslverr_o = r_pslverr;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with no wait states and one
// with three, driven by a simple APB master model selected by m_sel.
module tb_apb_reg_slave;

   logic        pclk;
   logic        preset_n;
   logic        m_sel;
   logic        m_psel;
   logic        m_penable;
   logic [31:0] m_addr;
   logic        m_write;
   logic [31:0] m_wdata;
   logic        w_pready;
   logic        w_pslverr;
   logic [31:0] w_prdata;
   int          n_checks;
   int          n_errors;

   apb_reg_slave_if bus0 ();
   apb_reg_slave_if bus3 ();

   assign bus0.psel_i    = m_psel && !m_sel;
   assign bus0.penable_i = m_penable && !m_sel;
   assign bus0.paddr_i   = m_addr;
   assign bus0.pwrite_i  = m_write;
   assign bus0.pwdata_i  = m_wdata;
   assign bus3.psel_i    = m_psel && m_sel;
   assign bus3.penable_i = m_penable && m_sel;
   assign bus3.paddr_i   = m_addr;
   assign bus3.pwrite_i  = m_write;
   assign bus3.pwdata_i  = m_wdata;

   assign w_pready  = m_sel ? bus3.pready_o  : bus0.pready_o;
   assign w_pslverr = m_sel ? bus3.pslverr_o : bus0.pslverr_o;
   assign w_prdata  = m_sel ? bus3.prdata_o  : bus0.prdata_o;

   apb_reg_slave #(.WAIT_CYCLES(0)) dut0 (.pclk(pclk), .preset_n(preset_n), .apb(bus0));
   apb_reg_slave #(.WAIT_CYCLES(3)) dut3 (.pclk(pclk), .preset_n(preset_n), .apb(bus3));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // One APB transfer; returns at #1 after the edge that ends the READY cycle,
   // with psel/penable still high so a following call is back-to-back.
   task automatic xfer(input logic d, input logic [31:0] a, input logic wr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int cyc, output logic pre);
      m_sel = d; m_psel = 1'b1; m_penable = 1'b0;
      m_addr = a; m_write = wr; m_wdata = wd;
      @(negedge pclk); pre = w_pready;
      @(posedge pclk); #1; m_penable = 1'b1;
      cyc = 0; rd = 32'h0; er = 1'b0;
      for (int i = 1; i <= 20 && cyc == 0; i++) begin
         @(negedge pclk);
         if (w_pready) begin cyc = i; rd = w_prdata; er = w_pslverr; end
         @(posedge pclk); #1;
      end
   endtask

   task automatic bus_idle(output logic rdy);
      m_psel = 1'b0; m_penable = 1'b0;
      @(negedge pclk); rdy = w_pready;
      @(posedge pclk); #1;
   endtask

   task automatic test_reset;
      preset_n = 1'b0; m_sel = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
      m_addr = 32'h0; m_write = 1'b0; m_wdata = 32'h0;
      #12;
      n_checks++; if (bus0.pready_o !== 1'b0) begin n_errors++; $display("FAIL reset pready0: got %b want 0", bus0.pready_o); end
      n_checks++; if (bus0.pslverr_o !== 1'b0) begin n_errors++; $display("FAIL reset pslverr0: got %b want 0", bus0.pslverr_o); end
      n_checks++; if (bus0.prdata_o !== 32'h0) begin n_errors++; $display("FAIL reset prdata0: got %h want 0", bus0.prdata_o); end
      n_checks++; if (bus3.pready_o !== 1'b0) begin n_errors++; $display("FAIL reset pready3: got %b want 0", bus3.pready_o); end
      n_checks++; if (bus3.prdata_o !== 32'h0) begin n_errors++; $display("FAIL reset prdata3: got %h want 0", bus3.prdata_o); end
      @(negedge pclk); preset_n = 1'b1;
      @(posedge pclk); #1;
   endtask

   task automatic test_id_read;
      logic [31:0] rd; logic er, pre, rdy; int cyc;
      xfer(1'b0, 32'h0, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (rd !== 32'hA5B0_0001) begin n_errors++; $display("FAIL id_read rdata: got %h want a5b00001", rd); end
      n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL id_read pslverr: got %b want 0", er); end
      n_checks++; if (cyc !== 2) begin n_errors++; $display("FAIL id_read latency: got %0d want 2", cyc); end
      n_checks++; if ({pre, rdy} !== 2'b00) begin n_errors++; $display("FAIL id_read pulse_width: pready before/after %b want 00", {pre, rdy}); end
   endtask

   task automatic test_write_read;
      logic [31:0] rd; logic er, pre, rdy; int cyc;
      xfer(1'b0, 32'h4, 1'b1, 32'hDEAD_BEEF, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, cyc} !== {1'b0, 32'd2}) begin n_errors++; $display("FAIL wr4 resp: err=%b cyc=%0d want err=0 cyc=2", er, cyc); end
      xfer(1'b0, 32'h4, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL rd4 rdata: got %h want deadbeef", rd); end
      n_checks++; if (er !== 1'b0) begin n_errors++; $display("FAIL rd4 pslverr: got %b want 0", er); end
      xfer(1'b0, 32'h8, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, rd} !== 33'h0) begin n_errors++; $display("FAIL rd8 untouched: err=%b rdata=%h want 0/0", er, rd); end
   endtask

   task automatic test_wait_states;
      logic [31:0] rd; logic er, pre, rdy; int cyc;
      xfer(1'b1, 32'h1C, 1'b1, 32'h1234_5678, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL ws_write latency: got %0d want 5", cyc); end
      n_checks++; if ({er, rdy} !== 2'b00) begin n_errors++; $display("FAIL ws_write err/after: got %b want 00", {er, rdy}); end
      xfer(1'b1, 32'h1C, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL ws_read rdata: got %h want 12345678", rd); end
      n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL ws_read latency: got %0d want 5", cyc); end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er, pre, rdy; int cyc;
      xfer(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, cyc} !== {1'b1, 32'd2}) begin n_errors++; $display("FAIL wr_id resp: err=%b cyc=%0d want 1/2", er, cyc); end
      xfer(1'b0, 32'h0, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (rd !== 32'hA5B0_0001) begin n_errors++; $display("FAIL id_after_wr: got %h want a5b00001", rd); end
      xfer(1'b0, 32'h20, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL rd_range: err=%b rdata=%h want 1/0", er, rd); end
      xfer(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL rd_top: err=%b rdata=%h want 1/0", er, rd); end
      xfer(1'b0, 32'h1C, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, rd} !== 33'h0) begin n_errors++; $display("FAIL rd_last: err=%b rdata=%h want 0/0", er, rd); end
      xfer(1'b0, 32'h6, 1'b1, 32'h0000_0055, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (er !== 1'b1) begin n_errors++; $display("FAIL wr_misaligned pslverr: got %b want 1", er); end
      xfer(1'b0, 32'h4, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL reg1_after_misaligned: got %h want deadbeef", rd); end
   endtask

   task automatic test_abort;
      logic [31:0] rd; logic er, pre, rdy; int cyc; int pulses;
      m_sel = 1'b1; m_psel = 1'b1; m_penable = 1'b0;
      m_addr = 32'h8; m_write = 1'b1; m_wdata = 32'hCAFE_0008;
      @(posedge pclk); #1; m_penable = 1'b1;
      @(posedge pclk); #1;
      @(posedge pclk); #1; m_psel = 1'b0;
      pulses = 0;
      repeat (8) begin @(negedge pclk); if (w_pready) pulses++; end
      m_penable = 1'b0;
      @(posedge pclk); #1;
      n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL abort pready: got %0d pulses want 0", pulses); end
      xfer(1'b1, 32'h8, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, rd} !== 33'h0) begin n_errors++; $display("FAIL abort reg2: err=%b rdata=%h want 0/0", er, rd); end
      n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL abort recover latency: got %0d want 5", cyc); end

      m_psel = 1'b1; m_penable = 1'b0;
      m_addr = 32'hC; m_write = 1'b1; m_wdata = 32'h3333_3333;
      @(posedge pclk); #1; m_penable = 1'b1;
      @(posedge pclk); #1;
      @(posedge pclk); #1; preset_n = 1'b0;
      #1;
      n_checks++; if ({bus3.pready_o, bus3.pslverr_o, bus3.prdata_o} !== 34'h0) begin
         n_errors++; $display("FAIL reset_midwait outputs: rdy=%b err=%b rdata=%h want 0", bus3.pready_o, bus3.pslverr_o, bus3.prdata_o); end
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      n_checks++; if (bus3.pready_o !== 1'b0) begin n_errors++; $display("FAIL reset_held pready: got %b want 0", bus3.pready_o); end
      m_psel = 1'b0; m_penable = 1'b0; preset_n = 1'b1;
      @(posedge pclk); #1;
      xfer(1'b1, 32'hC, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if ({er, rd} !== 33'h0) begin n_errors++; $display("FAIL reset_midwait reg3: err=%b rdata=%h want 0/0", er, rd); end
      xfer(1'b1, 32'h1C, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_clears reg7: got %h want 0", rd); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; logic er, pre, rdy; int cyc;
      xfer(1'b0, 32'h10, 1'b1, 32'h0BAD_F00D, rd, er, cyc, pre);
      n_checks++; if ({er, cyc} !== {1'b0, 32'd2}) begin n_errors++; $display("FAIL b2b write: err=%b cyc=%0d want 0/2", er, cyc); end
      xfer(1'b0, 32'h10, 1'b0, 32'h0, rd, er, cyc, pre);
      bus_idle(rdy);
      n_checks++; if (pre !== 1'b0) begin n_errors++; $display("FAIL b2b setup pready: got %b want 0", pre); end
      n_checks++; if (rd !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL b2b read rdata: got %h want 0badf00d", rd); end
      n_checks++; if ({er, cyc} !== {1'b0, 32'd2}) begin n_errors++; $display("FAIL b2b read resp: err=%b cyc=%0d want 0/2", er, cyc); end
      n_checks++; if (rdy !== 1'b0) begin n_errors++; $display("FAIL b2b pulse_end: got %b want 0", rdy); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_id_read();
      test_write_read();
      test_wait_states();
      test_errors();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1);
   end

endmodule
